// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32 x XLEN integer register file, two combinational read
// ports (A, B), one debug read port and one synchronous write port.
// x0 has no storage and always reads zero. x2/x3 reset to SP_INIT/GP_INIT.
// Optional macro REGFILE_BYPASS_EN adds a same-cycle write-through bypass
// on every read port; the default build returns stored contents only.
module regfile_2r1w #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] SP_INIT = 32'h0000_0FFC,
   parameter logic [XLEN-1:0] GP_INIT = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             rs1_addr,
   input  logic [4:0]             rs2_addr,
   output logic signed [XLEN-1:0] rs1_data,
   output logic signed [XLEN-1:0] rs2_data,
   input  logic [4:0]             rd_addr,
   input  logic [XLEN-1:0]        rd_data,
   input  logic                   reg_write,
   input  logic [4:0]             dbg_addr,
   output logic [XLEN-1:0]        dbg_data
);

   // Storage exists only for x1..x31.
   logic [XLEN-1:0] regs_q [1:31];
   logic [XLEN-1:0] regs_d [1:31];
   // Full 32-entry read view with x0 tied to zero.
   logic [XLEN-1:0] view   [0:31];

`ifdef REGFILE_BYPASS_EN
   // A write that may be forwarded this cycle; never while in reset.
   logic wr_hit;
   assign wr_hit = rst_n && reg_write && (rd_addr != 5'd0);
`endif

   // Next-state: apply the write unless it targets x0 or is disabled.
   always_comb begin
      regs_d = regs_q;
      if (reg_write && (rd_addr != 5'd0)) begin
         regs_d[rd_addr] = rd_data;
      end
   end

   // Array update; reset wins over a simultaneous write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) begin
            regs_q[i] <= '0;
         end
         regs_q[2] <= SP_INIT;
         regs_q[3] <= GP_INIT;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Build the read view with the hardwired-zero x0 entry.
   always_comb begin
      view[0] = '0;
      for (int i = 1; i < 32; i++) begin
         view[i] = regs_q[i];
      end
   end

   // Read port A: stored value, optionally overridden by the live write.
   always_comb begin
      rs1_data = view[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (rd_addr == rs1_addr)) begin
         rs1_data = rd_data;
      end
`endif
   end

   // Read port B: same rules as port A.
   always_comb begin
      rs2_data = view[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (rd_addr == rs2_addr)) begin
         rs2_data = rd_data;
      end
`endif
   end

   // Debug read port: same rules as port A.
   always_comb begin
      dbg_data = view[dbg_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (rd_addr == dbg_addr)) begin
         dbg_data = rd_data;
      end
`endif
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed and random self-checking bench for regfile_2r1w.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// a further unit later, well away from the next edge.
module tb_regfile_2r1w;

   localparam logic [31:0] SP_INIT = 32'h0000_0FFC;
   localparam logic [31:0] GP_INIT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
   logic [31:0] rs1_data, rs2_data, rd_data, dbg_data;
   logic        reg_write;

   int checks   = 0;
   int failures = 0;

   // Reference array model, x0 entry kept at zero.
   logic [31:0] m [0:31];

   regfile_2r1w dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .reg_write (reg_write),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value for an address given current inputs and model.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      v = (a == 5'd0) ? 32'h0 : m[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && reg_write && rd_addr != 5'd0 && rd_addr == a) v = rd_data;
`endif
      return v;
   endfunction

   // Update the model from the current inputs, then take one clock edge.
   task automatic do_cycle();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m[i] = 32'h0;
         m[2] = SP_INIT;
         m[3] = GP_INIT;
      end else if (reg_write && rd_addr != 5'd0) begin
         m[rd_addr] = rd_data;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
      rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
      @(posedge clk); #1;

      // Reset values: two reset edges, then sweep the debug port.
      do_cycle();
      do_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         chk($sformatf("reset_x%0d", i), dbg_data, (i == 2) ? 32'h0000_0FFC : 32'h0);
      end

      // Basic write then read on both ports.
      reg_write = 1'b1; rd_addr = 5'd5;  rd_data = 32'hDEAD_BEEF; do_cycle();
      rd_addr = 5'd31; rd_data = 32'h8000_0001; do_cycle();
      reg_write = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd31; #1;
      chk("rd_x5",  rs1_data, 32'hDEAD_BEEF);
      chk("rd_x31", rs2_data, 32'h8000_0001);
      chk("x31_neg", {31'b0, rs2_data[31]}, 32'h1);

      // x0 protection, checked during and after the write attempt.
      reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
      rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
      chk("x0_same_cycle_a", rs1_data, 32'h0);
      chk("x0_same_cycle_b", rs2_data, 32'h0);
      do_cycle();
      reg_write = 1'b0; #1;
      chk("x0_after_a", rs1_data, 32'h0);
      chk("x0_after_b", rs2_data, 32'h0);

      // Disabled write leaves x7 alone.
      reg_write = 1'b0; rd_addr = 5'd7; rd_data = 32'h1; rs1_addr = 5'd7; do_cycle();
      chk("x7_no_we", rs1_data, 32'h0);

      // Same-cycle write/read collision on x7.
      reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'h1234; rs1_addr = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
      chk("x7_collide", rs1_data, 32'h1234);
`else
      chk("x7_collide", rs1_data, 32'h0);
`endif
      do_cycle();
      reg_write = 1'b0; #1;
      chk("x7_next", rs1_data, 32'h1234);

      // Dual read of one address.
      rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
      chk("dual_a", rs1_data, 32'hDEAD_BEEF);
      chk("dual_b", rs2_data, 32'hDEAD_BEEF);

      // Fill x1..x31 with index * 0x01010101 and verify via debug port.
      reg_write = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rd_addr = 5'(i); rd_data = 32'(i) * 32'h0101_0101; do_cycle();
      end
      reg_write = 1'b0;
      for (int i = 1; i < 32; i++) begin
         dbg_addr = 5'(i); #1;
         chk($sformatf("fill_x%0d", i), dbg_data, 32'(i) * 32'h0101_0101);
      end

      // Reset on the same edge as a write to x9: the write is dropped.
      rst_n = 1'b0; reg_write = 1'b1; rd_addr = 5'd9; rd_data = 32'hAAAA_AAAA;
      rs1_addr = 5'd9; #1;
      chk("x9_in_reset_no_bypass", rs1_data, 32'h0909_0909);
      do_cycle();
      rst_n = 1'b1; reg_write = 1'b0; #1;
      chk("x9_after_reset", rs1_data, 32'h0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i); #1;
         chk($sformatf("midreset_x%0d", i), dbg_data, (i == 2) ? 32'h0000_0FFC : 32'h0);
      end

      // Random regression against the reference model.
      for (int n = 0; n < 10000; n++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         reg_write = 1'($urandom_range(0, 1));
         rd_addr   = 5'($urandom_range(0, 31));
         rd_data   = $urandom;
         rs1_addr  = 5'($urandom_range(0, 31));
         rs2_addr  = ($urandom_range(0, 7) == 0) ? rd_addr : 5'($urandom_range(0, 31));
         dbg_addr  = ($urandom_range(0, 7) == 0) ? rd_addr : 5'($urandom_range(0, 31));
         #1;
         v = exp_rd(rs1_addr); chk("rand_rs1", rs1_data, v);
         v = exp_rd(rs2_addr); chk("rand_rs2", rs2_data, v);
         v = exp_rd(dbg_addr); chk("rand_dbg", dbg_data, v);
         do_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
